// File: rtl/serial_subtractor_module.sv
// Digit-serial unsigned subtractor: destination2 = operand0 - operand1, LSD first,
// with a start/busy/done handshake and the shared four-destination result fan-out.
module serial_subtractor_module #(
    parameter int bit_width   = 8,
    parameter int count0      = 0,
    parameter int count1      = 0,
    parameter int digit_width = 1,
    localparam int sel0_w     = (count0 > 0) ? $clog2(count0 + 1) : 1,
    localparam int sel1_w     = (count1 > 0) ? $clog2(count1 + 1) : 1,
    localparam int src0_w     = (count0 > 0) ? count0 * bit_width : 1,
    localparam int src1_w     = (count1 > 0) ? count1 * bit_width : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [sel0_w-1:0]    selector0,
    input  logic [sel1_w-1:0]    selector1,
    input  logic [src0_w-1:0]    source0,
    input  logic [src1_w-1:0]    source1,
    output logic                 busy,
    output logic                 done,
    output logic [bit_width-1:0] destination0,
    output logic [bit_width-1:0] destination1,
    output logic [bit_width-1:0] destination2,
    output logic [bit_width-1:0] destination3
);

    localparam int n_digits = bit_width / digit_width;
    localparam int cnt_w    = (n_digits > 1) ? $clog2(n_digits) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state, state_next;
    logic [bit_width-1:0] a_reg, b_reg;
    logic [bit_width-1:0] a_sh, b_sh;
    logic [bit_width-1:0] diff, diff_next;
    logic                 borrow;
    logic [cnt_w-1:0]     cnt;
    logic [bit_width-1:0] op_a, op_b;
    logic [digit_width:0] digit_res;

    // Word select: s in 1..count picks word s-1; 0 or out-of-range gives zero.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < count0; i++)
            if (int'(selector0) == i + 1)
                op_a = source0[i*bit_width +: bit_width];
        for (int i = 0; i < count1; i++)
            if (int'(selector1) == i + 1)
                op_b = source1[i*bit_width +: bit_width];
    end

    // Top bit of the (digit_width+1)-bit difference is the outgoing borrow.
    assign digit_res = {1'b0, a_sh[digit_width-1:0]}
                     - {1'b0, b_sh[digit_width-1:0]}
                     - {{digit_width{1'b0}}, borrow};

    generate
        if (digit_width == bit_width) begin : g_full
            assign diff_next = digit_res[digit_width-1:0];
        end else begin : g_part
            assign diff_next = {digit_res[digit_width-1:0], diff[bit_width-1:digit_width]};
        end
    endgenerate

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (cnt == cnt_w'(n_digits - 1)) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: all datapath registers are cleared, since the destinations must read zero after reset.
            state  <= S_IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg  <= op_a;
                        b_reg  <= op_b;
                        a_sh   <= op_a;
                        b_sh   <= op_b;
                        diff   <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> digit_width;
                    b_sh   <= b_sh >> digit_width;
                    diff   <= diff_next;
                    borrow <= digit_res[digit_width];
                    cnt    <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state == S_RUN);
    assign done         = (state == S_DONE);
    assign destination0 = a_reg;
    assign destination1 = b_reg;
    assign destination2 = diff;
    assign destination3 = {bit_width{borrow}};

endmodule
